obi_ram_bridge: RTL

OBI_RAM_BRIDGE -- requirements
Module: obi_ram_bridge

---
 rtl/obi_ram_bridge.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/obi_ram_bridge.sv
// OBI data-port bridge: routes core accesses to a dual-port RAM port B or to
// console / exit / out-of-bounds MMIO handling, with single-cycle responses.
module obi_ram_bridge #(
    parameter int unsigned ADDR_WIDTH   = 22,
    parameter int unsigned MAXBLKSIZE   = 17,
    parameter logic [31:0] CONSOLE_ADDR = 32'h2000_0000,
    parameter logic [31:0] EXIT_ADDR    = 32'h2000_0004
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    input  logic [31:0]           data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,

    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i,

    output logic                  putc_valid_o,
    output logic [7:0]            putc_data_o,
    input  logic                  putc_ready_i,
    output logic                  exit_valid_o,
    output logic [31:0]           exit_code_o,
    output logic                  oob_o
);

    localparam int unsigned RamShift = MAXBLKSIZE + 2;

    typedef enum logic [1:0] {RspNone, RspRam, RspReg} rsp_e;
    typedef enum logic {ConEmpty, ConFull} con_e;

    logic        is_ram, is_con, is_exit, is_oob;
    logic        granted, con_wr;
    rsp_e        rsp_q, rsp_d;
    logic        rvalid_q;
    logic [31:0] reg_q, reg_d;
    con_e        con_q, con_d;
    logic [7:0]  putc_data_q, putc_data_d;
    logic        exit_valid_q;
    logic [31:0] exit_code_q;
    logic        oob_q;

    // RAM decode takes priority; MMIO addresses sit above the RAM window.
    always_comb begin
        is_ram  = (data_addr_i >> RamShift) == 32'd0;
        is_con  = !is_ram && (data_addr_i == CONSOLE_ADDR);
        is_exit = !is_ram && (data_addr_i == EXIT_ADDR);
        is_oob  = !is_ram && !is_con && !is_exit;
    end

    // Only a console write into a full, stalled buffer is held off.
    assign data_gnt_o = !(is_con && data_we_i && (con_q == ConFull) && !putc_ready_i);
    assign granted    = data_req_i && data_gnt_o;
    assign con_wr     = granted && is_con && data_we_i;

    assign ram_en_o    = granted && is_ram;
    assign ram_addr_o  = data_addr_i[ADDR_WIDTH-1:0];
    assign ram_we_o    = data_we_i;
    assign ram_be_o    = data_be_i;
    assign ram_wdata_o = data_wdata_i;

    // Console buffer: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            con_q       <= ConEmpty;
            putc_data_q <= 8'h00;
        end else begin
            con_q       <= con_d;
            putc_data_q <= putc_data_d;
        end
    end

    // Console buffer: next state
    always_comb begin
        con_d       = con_q;
        putc_data_d = con_wr ? data_wdata_i[7:0] : putc_data_q;
        unique case (con_q)
            ConEmpty: if (con_wr) con_d = ConFull;
            ConFull:  if (putc_ready_i && !con_wr) con_d = ConEmpty;
            default:  con_d = ConEmpty;
        endcase
    end

    // Console buffer: outputs
    always_comb begin
        putc_valid_o = (con_q == ConFull);
        putc_data_o  = putc_data_q;
    end

    always_comb begin
        rsp_d = rsp_q;
        reg_d = reg_q;
        if (granted) begin
            rsp_d = is_ram ? RspRam : (is_oob ? RspNone : RspReg);
            reg_d = 32'd0;
            if (is_con && !data_we_i)  reg_d = {31'd0, putc_valid_o};
            if (is_exit && !data_we_i) reg_d = exit_code_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q     <= 1'b0;
            rsp_q        <= RspNone;
            reg_q        <= 32'd0;
            exit_valid_q <= 1'b0;
            exit_code_q  <= 32'd0;
            oob_q        <= 1'b0;
        end else begin
            rvalid_q <= granted;
            rsp_q    <= rsp_d;
            reg_q    <= reg_d;
            if (granted && is_exit && data_we_i && !exit_valid_q) begin
                exit_valid_q <= 1'b1;
                exit_code_q  <= data_wdata_i;
            end
            if (granted && is_oob) oob_q <= 1'b1;
        end
    end

    always_comb begin
        unique case (rsp_q)
            RspRam:  data_rdata_o = ram_rdata_i;
            RspReg:  data_rdata_o = reg_q;
            default: data_rdata_o = 32'd0;
        endcase
    end

    assign data_rvalid_o = rvalid_q;
    assign exit_valid_o  = exit_valid_q;
    assign exit_code_o   = exit_code_q;
    assign oob_o         = oob_q;

endmodule
